// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style character LCD bus responder with a 2x16 character buffer.
// Define LCD_RESP_BUSY_EN to model busy timing; otherwise only the clear fill occupies the bus.
module lcd_responder #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [7:0] LCD_DATA_in,
  output logic [7:0] LCD_DATA_out,
  output logic       LCD_DATA_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cur_addr,
  output logic       display_on,
  output logic       busy,
  output logic       cmd_err,
  output logic       bus_viol
);
`ifdef LCD_RESP_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif
  localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 33);
  localparam bit          CLEAR_TAIL = BUSY_EN && (CLEAR_CYCLES > 32);
  typedef enum logic [1:0] {IDLE, CLEAR, EXEC} state_t;
  state_t           state_q, state_d;
  logic [1:0]       en_sync_q, en_sync_d, rs_sync_q, rs_sync_d, rw_sync_q, rw_sync_d;
  logic [1:0][7:0]  dat_sync_q, dat_sync_d;
  logic             en_prev_q, en_prev_d;
  logic             cap_rs_q, cap_rs_d, cap_rw_q, cap_rw_d;
  logic [7:0]       cap_dat_q, cap_dat_d;
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d, disp_q, disp_d, err_q, err_d, viol_q, viol_d;
  logic [4:0]       fill_q, fill_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0][7:0] buf_q, buf_d;
  logic             en_s, commit, rd_commit, wr_commit, is_clear;
  logic [4:0]       idx;
  // Lines map onto a 5-bit linear index, so stepping wraps 0x0F<->0x40 and 0x4F<->0x00 naturally.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [4:0] p;
    p = {a[6], a[3:0]} + (inc ? 5'd1 : 5'd31);
    return {p[4], 2'b00, p[3:0]};
  endfunction
  assign en_s      = en_sync_q[1];
  assign commit    = en_prev_q & ~en_s;
  assign rd_commit = commit & cap_rw_q & cap_rs_q;
  assign wr_commit = commit & ~cap_rw_q;
  assign is_clear  = ~cap_rs_q && (cap_dat_q == 8'h01);
  assign idx       = {ac_q[6], ac_q[3:0]};
  always_comb begin
    en_sync_d  = {en_sync_q[0], LCD_EN};
    rs_sync_d  = {rs_sync_q[0], LCD_RS};
    rw_sync_d  = {rw_sync_q[0], LCD_RW};
    dat_sync_d = {dat_sync_q[0], LCD_DATA_in};
    en_prev_d  = en_s;
    cap_rs_d   = en_s ? rs_sync_q[1] : cap_rs_q;
    cap_rw_d   = en_s ? rw_sync_q[1] : cap_rw_q;
    cap_dat_d  = en_s ? dat_sync_q[1] : cap_dat_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    buf_d      = buf_q;
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    err_d      = 1'b0;
    viol_d     = viol_q;
    case (state_q)
      CLEAR: begin
        buf_d[fill_q] = 8'h20;
        fill_d        = fill_q + 5'd1;
        if (fill_q == 5'd31) begin
          state_d = CLEAR_TAIL ? EXEC : IDLE;
          cnt_d   = CLEAR_LOAD;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd0) state_d = IDLE;
      end
      default: ;
    endcase
    if (rd_commit) ac_d = ac_step(ac_q, id_q);
    if (wr_commit && state_q != IDLE) viol_d = 1'b1;
    else if (wr_commit) begin
      if (cap_rs_q) begin
        buf_d[idx] = cap_dat_q;
        ac_d       = ac_step(ac_q, id_q);
      end else if (cap_dat_q[7]) begin
        if (cap_dat_q[5:4] == 2'b00) ac_d = cap_dat_q[6:0];
        else err_d = 1'b1;
      end else if (cap_dat_q[6:5] == 2'b00) begin
        if (cap_dat_q[4]) begin
          if (!cap_dat_q[3]) ac_d = ac_step(ac_q, cap_dat_q[2]);
        end else if (cap_dat_q[3]) disp_d = cap_dat_q[2];
        else if (cap_dat_q[2]) id_d = cap_dat_q[1];
        else if (cap_dat_q[1]) ac_d = 7'h00;
        else if (cap_dat_q[0]) begin
          ac_d    = 7'h00;
          id_d    = 1'b1;
          fill_d  = 5'd0;
          state_d = CLEAR;
        end
      end
      if (BUSY_EN && !is_clear) begin
        state_d = EXEC;
        cnt_d   = BUSY_LOAD;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      en_sync_q  <= '0;
      rs_sync_q  <= '0;
      rw_sync_q  <= '0;
      dat_sync_q <= '0;
      en_prev_q  <= 1'b0;
      cap_rs_q   <= 1'b0;
      cap_rw_q   <= 1'b0;
      cap_dat_q  <= 8'h00;
      cnt_q      <= 16'd0;
      fill_q     <= 5'd0;
      buf_q      <= {32{8'h20}};
      ac_q       <= 7'h00;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      err_q      <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_sync_q  <= en_sync_d;
      rs_sync_q  <= rs_sync_d;
      rw_sync_q  <= rw_sync_d;
      dat_sync_q <= dat_sync_d;
      en_prev_q  <= en_prev_d;
      cap_rs_q   <= cap_rs_d;
      cap_rw_q   <= cap_rw_d;
      cap_dat_q  <= cap_dat_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      buf_q      <= buf_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      err_q      <= err_d;
      viol_q     <= viol_d;
    end
  end
  assign busy         = BUSY_EN && (state_q != IDLE);
  assign LCD_DATA_oe  = en_s & rw_sync_q[1];
  assign LCD_DATA_out = !LCD_DATA_oe ? 8'h00 : rs_sync_q[1] ? buf_q[idx] : {busy, ac_q};
  assign rd_char      = buf_q[rd_addr];
  assign cur_addr     = ac_q;
  assign display_on   = disp_q;
  assign cmd_err      = err_q;
  assign bus_viol     = viol_q;
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: randomized bus traffic checked every cycle against a behavioural LCD model,
// plus directed scenarios with hand-computed expectations.
module tb_lcd_responder;
`ifdef LCD_RESP_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b0;
  logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
  logic [7:0] LCD_DATA_in = 8'h00;
  logic [7:0] LCD_DATA_out, rd_char;
  logic       LCD_DATA_oe, display_on, busy, cmd_err, bus_viol;
  logic [4:0] rd_addr = 5'd0;
  logic [6:0] cur_addr;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_buf [32];
  logic [6:0] m_ac;
  logic       m_id, m_disp, m_err, m_viol;
  int         blk_left, fill_left, pend;
  logic       p_rs, p_rw;
  logic [7:0] p_d;
  logic       h_en1, h_en2, h_rw1, h_rw2, h_rs1, h_rs2;
  bit         hold;
  logic [4:0] hold_addr;
  logic [7:0] rdat;
  logic       roe;
  int         cnt;

  always #5 clk = ~clk;

  lcd_responder dut (
    .clk(clk), .rst(rst), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_DATA_in(LCD_DATA_in), .LCD_DATA_out(LCD_DATA_out), .LCD_DATA_oe(LCD_DATA_oe),
    .rd_addr(rd_addr), .rd_char(rd_char), .cur_addr(cur_addr), .display_on(display_on),
    .busy(busy), .cmd_err(cmd_err), .bus_viol(bus_viol)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ac2pos(input logic [6:0] a);
    return int'(a[6]) * 16 + int'(a[3:0]);
  endfunction

  function automatic logic [6:0] pos2ac(input int p);
    return {p[4], 2'b00, p[3:0]};
  endfunction

  function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
    return pos2ac(inc ? (ac2pos(a) + 1) % 32 : (ac2pos(a) + 31) % 32);
  endfunction

  task automatic model_reset();
    foreach (m_buf[i]) m_buf[i] = 8'h20;
    m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0; m_err = 1'b0; m_viol = 1'b0;
    blk_left = 0; fill_left = 0; pend = 0;
    {h_en1, h_en2, h_rw1, h_rw2, h_rs1, h_rs2} = '0;
  endtask

  task automatic apply(input bit was_blocked);
    bit clr;
    clr = 1'b0;
    if (p_rw) begin
      if (p_rs) m_ac = step(m_ac, m_id);
    end else if (was_blocked) m_viol = 1'b1;
    else begin
      if (p_rs) begin
        m_buf[ac2pos(m_ac)] = p_d;
        m_ac = step(m_ac, m_id);
      end else if (p_d >= 8'h80) begin
        if (p_d[6:0] <= 7'h0F || (p_d[6:0] >= 7'h40 && p_d[6:0] <= 7'h4F)) m_ac = p_d[6:0];
        else m_err = 1'b1;
      end else if (p_d >= 8'h20) begin
      end else if (p_d >= 8'h10) begin
        if (!p_d[3]) m_ac = step(m_ac, p_d[2]);
      end else if (p_d >= 8'h08) m_disp = p_d[2];
      else if (p_d >= 8'h04) m_id = p_d[1];
      else if (p_d >= 8'h02) m_ac = 7'h00;
      else if (p_d == 8'h01) begin
        clr = 1'b1;
        m_ac = 7'h00;
        m_id = 1'b1;
        foreach (m_buf[i]) m_buf[i] = 8'h20;
      end
      blk_left  = clr ? (BUSY_EN ? 64 : 32) : (BUSY_EN ? 40 : 0);
      fill_left = clr ? 32 : 0;
    end
  endtask

  // Model time advances on each rising edge; a transfer commits three edges after EN drops.
  initial forever begin
    bit wb;
    @(posedge clk);
    if (rst) begin
      wb = blk_left > 0;
      if (blk_left > 0) blk_left--;
      if (fill_left > 0) fill_left--;
      m_err = 1'b0;
      h_en2 = h_en1; h_rw2 = h_rw1; h_rs2 = h_rs1;
      h_en1 = LCD_EN; h_rw1 = LCD_RW; h_rs1 = LCD_RS;
      if (pend > 0) begin
        pend--;
        if (pend == 0) apply(wb);
      end
    end
  end

  initial forever begin
    logic eb;
    @(posedge clk);
    #2;
    rd_addr = hold ? hold_addr : 5'($urandom);
    #1;
    eb = BUSY_EN && blk_left > 0;
    chk("cur_addr", 8'(cur_addr), 8'(m_ac));
    chk("display_on", 8'(display_on), 8'(m_disp));
    chk("busy", 8'(busy), 8'(eb));
    chk("bus_viol", 8'(bus_viol), 8'(m_viol));
    chk("cmd_err", 8'(cmd_err), 8'(m_err));
    chk("data_oe", 8'(LCD_DATA_oe), 8'(h_en2 & h_rw2));
    if (h_en2 && h_rw2 && !(h_rs2 && fill_left > 0))
      chk("data_out", LCD_DATA_out, h_rs2 ? m_buf[ac2pos(m_ac)] : {eb, m_ac});
    if (fill_left == 0) chk("rd_char", rd_char, m_buf[rd_addr]);
  end

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      output logic [7:0] od, output logic ooe);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA_in = d; LCD_EN = 1'b1;
    repeat (3) @(negedge clk);
    od = LCD_DATA_out; ooe = LCD_DATA_oe;
    LCD_EN = 1'b0;
    p_rs = rs; p_rw = rw; p_d = d; pend = 3;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; LCD_EN = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic peek(input logic [4:0] a, input string nm, input logic [7:0] exp);
    hold = 1'b1; hold_addr = a;
    repeat (2) @(negedge clk);
    chk(nm, rd_char, exp);
    hold = 1'b0;
  endtask

  function automatic logic [7:0] pick_instr();
    logic [7:0] r;
    r = 8'($urandom);
    case ($urandom_range(0, 7))
      0: return 8'h01;
      1: return {6'b0, 1'b1, r[0]};
      2: return {5'b0, 1'b1, r[1:0]};
      3: return {4'b0, 1'b1, r[2:0]};
      4: return {3'b0, 1'b1, r[3:0]};
      5: return {1'b0, (r[6:5] == 2'b00) ? 2'b01 : r[6:5], r[4:0]};
      default: return {1'b1, r[6:0]};
    endcase
  endfunction

  initial begin
    model_reset();
    hold = 1'b1; hold_addr = 5'd5;
    repeat (3) @(negedge clk);
    chk("rst_cur_addr", 8'(cur_addr), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_display_on", 8'(display_on), 8'h00);
    chk("rst_bus_viol", 8'(bus_viol), 8'h00);
    chk("rst_cmd_err", 8'(cmd_err), 8'h00);
    chk("rst_oe", 8'(LCD_DATA_oe), 8'h00);
    chk("rst_data_out", LCD_DATA_out, 8'h00);
    chk("rst_rd_char", rd_char, 8'h20);
    rst = 1'b1; hold = 1'b0;
    xfer(0, 0, 8'h80, rdat, roe); idle(45);
    xfer(1, 0, 8'h48, rdat, roe);
    cnt = 0;
    repeat (80) begin @(negedge clk); cnt += int'(busy); end
    chk("write_busy_cycles", 8'(cnt), BUSY_EN ? 8'd40 : 8'd0);
    peek(5'd0, "write_0x48", 8'h48);
    chk("ac_after_write", 8'(cur_addr), 8'h01);
    xfer(0, 0, 8'h8F, rdat, roe); idle(45);
    xfer(1, 0, 8'h41, rdat, roe); idle(45);
    peek(5'd15, "write_col15", 8'h41);
    chk("ac_wrap_0x40", 8'(cur_addr), 8'h40);
    xfer(0, 0, 8'h04, rdat, roe); idle(45);
    xfer(0, 0, 8'hC0, rdat, roe); idle(45);
    xfer(1, 0, 8'h42, rdat, roe); idle(45);
    peek(5'd16, "write_line1", 8'h42);
    chk("ac_dec_wrap_0x0f", 8'(cur_addr), 8'h0F);
    xfer(0, 0, 8'h0C, rdat, roe); idle(45);
    chk("display_on_set", 8'(display_on), 8'h01);
    xfer(0, 0, 8'h01, rdat, roe);
    cnt = 0;
    repeat (100) begin @(negedge clk); cnt += int'(busy); end
    chk("clear_busy_cycles", 8'(cnt), BUSY_EN ? 8'd64 : 8'd0);
    for (int i = 0; i < 32; i++) peek(5'(i), "clear_fill", 8'h20);
    chk("clear_ac", 8'(cur_addr), 8'h00);
    xfer(0, 0, 8'h95, rdat, roe);
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(cmd_err); end
    chk("cmd_err_pulses", 8'(cnt), 8'd1);
    chk("bad_ddram_ac", 8'(cur_addr), 8'h00);
    idle(45);
    xfer(0, 0, 8'h01, rdat, roe); idle(2);
    xfer(1, 0, 8'h55, rdat, roe); idle(100);
    chk("viol_set", 8'(bus_viol), 8'h01);
    peek(5'd0, "viol_buffer_kept", 8'h20);
    chk("viol_ac_kept", 8'(cur_addr), 8'h00);
    do_reset();
    xfer(0, 0, 8'h85, rdat, roe); idle(2);
    xfer(0, 1, 8'h00, rdat, roe);
    chk("status_read", rdat, BUSY_EN ? 8'h85 : 8'h05);
    chk("status_oe", 8'(roe), 8'h01);
    idle(45);
    xfer(0, 0, 8'h01, rdat, roe); idle(10);
    do_reset();
    xfer(1, 0, 8'h77, rdat, roe); idle(45);
    peek(5'd0, "post_abort_write", 8'h77);
    for (int t = 0; t < 150; t++) begin
      int k;
      logic [7:0] d;
      k = $urandom_range(0, 29);
      d = 8'($urandom);
      if (k == 0) do_reset();
      else if (k < 10) xfer(1, 0, d, rdat, roe);
      else if (k < 13) xfer(1, 1, d, rdat, roe);
      else if (k < 16) xfer(0, 1, d, rdat, roe);
      else xfer(0, 0, pick_instr(), rdat, roe);
      idle($urandom_range(1, 3) + (($urandom_range(0, 2) == 0) ? 70 : 0));
    end
    idle(80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
